// File: rtl/countdown_mod_m_1s_interval_pkg.sv
// Shared definitions for the countdown timer.
//   clogb2           : number of bits needed to hold a value (minimum 1)
//   state_t          : FSM state encoding, also exported as a debug output
//   DEFAULT_CLK_FREQ : clock cycles per one-second tick on the 50 MHz board clock
package countdown_mod_m_1s_interval_pkg;

  localparam int DEFAULT_CLK_FREQ = 50000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Bits needed to represent v itself (not v-1), so that a width derived
  // from M or CLK_FREQ can always hold the parameter value.
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/countdown_mod_m_1s_interval_if.sv
// Control/status bundle of the countdown timer.
//   load, load_value, start, stop : commands from the controlling logic
//   Q, running, expired, done     : registered status back to the controller
// Signalling: there is no back-pressure. Every command is a level that the
// timer samples on each rising clock edge; priority among simultaneous
// commands is load > start > stop. Status is valid every cycle.
interface countdown_mod_m_1s_interval_if
  import countdown_mod_m_1s_interval_pkg::*;
#(
  parameter int M = 60
);
  localparam int N = clogb2(M);

  logic         load;
  logic [N-1:0] load_value;
  logic         start;
  logic         stop;
  logic [N-1:0] Q;
  logic         running;
  logic         expired;
  logic         done;

  modport master (
    output load, load_value, start, stop,
    input  Q, running, expired, done
  );

  modport slave (
    input  load, load_value, start, stop,
    output Q, running, expired, done
  );
endinterface

// File: rtl/countdown_mod_m_1s_interval_tick.sv
// One-second prescaler for the countdown timer.
//   CLOCK_50 : system clock
//   aclr     : asynchronous reset, active low
//   clear    : synchronous return to 0 (wins over enable)
//   enable   : count this cycle
//   tick     : high during the last cycle of each second while enabled
// When enable drops the count holds, so a paused run keeps its partial second.
module tick_prescaler
  import countdown_mod_m_1s_interval_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ
) (
  input  logic CLOCK_50,
  input  logic aclr,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int P = clogb2(CLK_FREQ);
  localparam logic [P-1:0] LAST = P'(CLK_FREQ - 1);

  logic [P-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/countdown_mod_m_1s_interval.sv
// Loadable once-per-second down-counter with expiry flag.
//   CLOCK_50  : system clock, rising edge
//   aclr      : asynchronous reset, active low
//   bus       : slave side of the control/status bundle
//               (load/load_value/start/stop in, Q/running/expired/done out)
//   dbg_state : current FSM state for observation
// Q only decrements on a prescaler tick in RUN, and RUN is only entered with
// Q != 0, so Q can never go below zero.
module countdown_mod_m_1s_interval
  import countdown_mod_m_1s_interval_pkg::*;
#(
  parameter int M        = 60,
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ
) (
  input  logic                           CLOCK_50,
  input  logic                           aclr,
  countdown_mod_m_1s_interval_if.slave   bus,
  output state_t                         dbg_state
);
  localparam int N = clogb2(M);
  localparam logic [N-1:0] Q_MAX = N'(M - 1);
  localparam logic [N-1:0] Q_ONE = N'(1);

  state_t       state;
  state_t       state_next;
  logic [N-1:0] q;
  logic         done_r;
  logic         tick;
  logic         last_tick;

  tick_prescaler #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .aclr     (aclr),
    .clear    (bus.load),
    .enable   (state == RUN),
    .tick     (tick)
  );

  // This tick takes the count from 1 to 0.
  assign last_tick = tick && (q == Q_ONE);

  always_comb begin
    state_next = state;
    if (bus.load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, PAUSED: begin
          if (bus.start && (q != '0)) state_next = RUN;
        end
        RUN: begin
          // Expiry beats a simultaneous stop; start outranks stop.
          if (last_tick)                     state_next = EXPIRED;
          else if (bus.stop && !bus.start)   state_next = PAUSED;
        end
        EXPIRED: state_next = EXPIRED;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      q      <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.load) begin
        q <= (bus.load_value > Q_MAX) ? Q_MAX : bus.load_value;
      end else if (tick) begin
        q <= q - 1'b1;
        if (last_tick) done_r <= 1'b1;
      end
    end
  end

  assign bus.Q       = q;
  assign bus.running = (state == RUN);
  assign bus.expired = (state == EXPIRED);
  assign bus.done    = done_r;
  assign dbg_state   = state;
endmodule

// File: doc/countdown_mod_m_1s_interval.md
Name: countdown_mod_M_1s_interval

Overview:
Loadable down-counter that decrements once per second from a preset value to zero, then flags expiry. It is the counting-down counterpart of the team's mod-M 1 s up-counter and uses the same 50 MHz clock, prescaler scheme and width rules. Its intended uses are game/kitchen-style countdown displays and timeouts feeding the 7-segment path.

Parameters:
- M, default 60: counter modulus. Q ranges 0..M-1.
- CLK_FREQ, default 50000000: clock cycles per 1 s tick. Benches override this with a small value.
- N, derived: clogb2(M), where clogb2(v) is the number of bits needed to hold v. Not user-settable.
- P, derived: clogb2(CLK_FREQ). Prescaler width.

Ports:
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- aclr  in  1  asynchronous reset, active-low (0 = reset).
- load  in  1  synchronous load strobe.
- load_value  in  N  preset value.
- start  in  1  start/resume strobe, level-sampled each cycle.
- stop  in  1  pause strobe, level-sampled each cycle.
- Q  out  N  current count.
- running  out  1  high while in state RUN.
- expired  out  1  high while in state EXPIRED.
- done  out  1  one-cycle pulse on entry to EXPIRED.

Behaviour:
- Reset (aclr=0, asynchronous): state IDLE, Q=0, prescaler=0, running=0, expired=0, done=0. Deassertion is taken synchronously at the next edge.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Input priority each cycle: load > start > stop.
- load (any state):
  - Q <= load_value, saturated to M-1 if load_value > M-1.
  - prescaler <= 0; state <= IDLE; done=0.
- start:
  - In IDLE or PAUSED with Q != 0: go to RUN.
  - In IDLE with Q == 0: ignored, stays IDLE, done not asserted.
  - In RUN or EXPIRED: ignored.
- stop:
  - In RUN: go to PAUSED; prescaler holds its value, so a resumed run keeps the partial second.
  - In any other state: ignored.
- Prescaler:
  - Counts 0..CLK_FREQ-1 only in RUN and wraps to 0.
  - tick = (state==RUN) && (prescaler==CLK_FREQ-1), combinational.
  - The first decrement therefore occurs exactly CLK_FREQ cycles after the start edge.
- On tick in RUN:
  - Q <= Q-1.
  - If Q==1 (next Q is 0): state <= EXPIRED and done=1 for exactly that next cycle.
- EXPIRED: Q holds 0 and expired=1; only load (or reset) leaves this state.
- Q never wraps below 0: there is no modulo wrap in the down direction.
- Simultaneous events:
  - load and tick in the same cycle: load wins, no decrement.
  - stop and tick in the same cycle: the decrement happens, then PAUSED. If that decrement reaches 0, EXPIRED takes precedence over PAUSED.
- Reset asserted mid-run: immediate return to the reset values. No done pulse.
- Outputs are registered, except running and expired, which are decoded from the state register. No combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - the clogb2 function;
  - state encoding constants (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, EXPIRED=2'd3);
  - the default CLK_FREQ constant 50000000.
- Sub-module tick_prescaler #(CLK_FREQ):
  - ports CLOCK_50, aclr, clear, enable, tick;
  - holds the P-bit prescaler;
  - clear has priority over enable.
- Top-level module holds the FSM and the N-bit down-counter.

Test Plan:
- Reset then load=1, load_value=5, start, all with CLK_FREQ=4 -> Q steps 5,4,3,2,1,0, one step every 4 cycles after start. done is high for 1 cycle as Q reaches 0. expired stays 1 and running returns to 0.
- M=60, load_value=63 -> Q=59 (saturated). Start, then stop after 2 ticks plus 1 cycle -> Q=57 with running=0. Start again -> next decrement 3 cycles later, showing the partial second is retained.
- load_value=0, then start -> state stays IDLE, running=0, done never pulses.
- Run with Q=3, then assert load with load_value=7 on a tick cycle -> Q=7, state IDLE, no decrement that cycle.
- Run with Q=1, then stop on the tick cycle -> Q=0, expired=1, done pulses once. EXPIRED wins over PAUSED.
- aclr=0 mid-run at Q=4 -> Q=0, running=0, done=0 immediately, without waiting for a clock edge. After release, start is ignored until a new load.
